// File: rtl/instr_encoder.sv
// Packs MIPS R/I/J field sets into 32-bit words and queues {word, address} in a 2-entry FIFO.
// Optional legality checking and the sticky err flag are enabled by INSTR_ENCODER_CHECK_EN.
module instr_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        Op,
    input  logic [4:0]        Rs,
    input  logic [4:0]        Rt,
    input  logic [4:0]        Rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] waddr,
    output logic              err
);

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_J = 2'b10;

    function automatic logic [31:0] f_encode(
        input logic [1:0]  f,
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  sh,
        input logic [5:0]  fn,
        input logic [15:0] im,
        input logic [25:0] ad
    );
        logic [31:0] w;
        case (f)
            FMT_R:   w = {op, rs, rt, rd, sh, fn};
            FMT_I:   w = {op, rs, rt, im};
            FMT_J:   w = {op, ad};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    logic [1:0]        r_occ;
    logic [31:0]       r_head_instr;
    logic [ADDR_W-1:0] r_head_waddr;
    logic [31:0]       r_tail_instr;
    logic [ADDR_W-1:0] r_tail_waddr;
    logic [ADDR_W-1:0] r_cnt;

    logic        w_full;
    logic        w_accept;
    logic        w_legal;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_word;

    assign w_full    = (r_occ == 2'd2);
    assign in_ready  = ~w_full & ~reset & ~flush;
    assign out_valid = (r_occ != 2'd0);
    assign w_accept  = in_valid & in_ready;
    assign w_push    = w_accept & w_legal;
    assign w_pop     = out_valid & out_ready;
    assign w_word    = f_encode(fmt, Op, Rs, Rt, Rd, shamt, funct, imm, addr);
    assign instr     = r_head_instr;
    assign waddr     = r_head_waddr;

`ifdef INSTR_ENCODER_CHECK_EN
    function automatic logic f_legal(input logic [1:0] f, input logic [5:0] op);
        logic ok;
        case (f)
            FMT_R:   ok = (op == 6'd0);
            FMT_I:   ok = (op != 6'd0) && (op != 6'd2) && (op != 6'd3);
            FMT_J:   ok = (op == 6'd2) || (op == 6'd3);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic r_err;

    assign w_legal = f_legal(fmt, Op);
    assign err     = r_err;

    // Sticky illegal-format flag, cleared only by reset or flush.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_legal) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end
`else
    assign w_legal = 1'b1;
    assign err     = 1'b0;
`endif

    // Occupancy and address counter; the counter wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_occ <= 2'd0;
            r_cnt <= BASE_ADDR;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
            if (w_push) begin
                r_cnt <= r_cnt + ADDR_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // FIFO storage: the head register drives the outputs directly, so it holds when the FIFO drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_instr <= 32'h0000_0000;
            r_head_waddr <= BASE_ADDR;
            r_tail_instr <= 32'h0000_0000;
            r_tail_waddr <= BASE_ADDR;
        end else if (flush) begin
            r_head_instr <= r_head_instr;
            r_head_waddr <= r_head_waddr;
            r_tail_instr <= r_tail_instr;
            r_tail_waddr <= r_tail_waddr;
        end else begin
            if (w_push && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop))) begin
                r_head_instr <= w_word;
                r_head_waddr <= r_cnt;
            end else if (w_pop && (r_occ == 2'd2)) begin
                r_head_instr <= r_tail_instr;
                r_head_waddr <= r_tail_waddr;
            end else begin
                r_head_instr <= r_head_instr;
                r_head_waddr <= r_head_waddr;
            end
            if (w_push && (r_occ == 2'd1) && !w_pop) begin
                r_tail_instr <= w_word;
                r_tail_waddr <= r_cnt;
            end else begin
                r_tail_instr <= r_tail_instr;
                r_tail_waddr <= r_tail_waddr;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand sequences and a random run
// compared against a queue-based reference model.
module tb_instr_encoder;

    localparam int AW   = 2;
    localparam int BASE = 0;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic          in_ready, out_valid, err;
    logic [1:0]    fmt;
    logic [5:0]    Op, funct;
    logic [4:0]    Rs, Rt, Rd, shamt;
    logic [15:0]   imm;
    logic [25:0]   addr;
    logic [31:0]   instr;
    logic [AW-1:0] waddr;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(AW'(BASE))) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .Op(Op), .Rs(Rs), .Rt(Rt), .Rd(Rd), .shamt(shamt), .funct(funct),
        .imm(imm), .addr(addr), .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .waddr(waddr), .err(err)
    );

    typedef struct {
        logic [31:0] w;
        int          a;
    } ent_t;

    typedef struct {
        int          f, op, rs, rt, rd, sh, fn, im, ad;
        logic [31:0] exp;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    ent_t        q[$];
    int          m_cnt;
    bit          m_err;
    logic [31:0] last_w;
    int          last_a;
    bit          hold_ok;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_enc(input int f, op, rs, rt, rd, sh, fn, im, ad);
        longint r;
        case (f)
            0:       r = op * 2**26 + rs * 2**21 + rt * 2**16 + rd * 2**11 + sh * 2**6 + fn;
            1:       r = op * 2**26 + rs * 2**21 + rt * 2**16 + im;
            2:       r = op * 2**26 + ad;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    function automatic bit m_legal(input int f, input int op);
`ifdef INSTR_ENCODER_CHECK_EN
        case (f)
            0:       return op == 0;
            1:       return !(op == 0 || op == 2 || op == 3);
            2:       return op == 2 || op == 3;
            default: return 1'b0;
        endcase
`else
        return 1'b1;
`endif
    endfunction

    task automatic set_fields(input int f, op, rs, rt, rd, sh, fn, im, ad);
        fmt = 2'(f); Op = 6'(op); Rs = 5'(rs); Rt = 5'(rt); Rd = 5'(rd);
        shamt = 5'(sh); funct = 6'(fn); imm = 16'(im); addr = 26'(ad);
    endtask

    // One clock: check outputs against the model at negedge, then advance the model past posedge.
    task automatic cyc(output bit acc);
        bit          m_rdy, pop, rs_s, fl_s, lg;
        logic [31:0] enc;
        ent_t        e;
        @(negedge clk);
        rs_s  = reset;
        fl_s  = flush;
        m_rdy = (q.size() < 2) && !rs_s && !fl_s;
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("instr", instr, q[0].w);
            chk("waddr", {30'd0, waddr}, 32'(q[0].a));
        end else if (hold_ok) begin
            chk("hold_instr", instr, last_w);
            chk("hold_waddr", {30'd0, waddr}, 32'(last_a));
        end
        chk("err", {31'd0, err}, {31'd0, m_err});
        acc = in_valid && m_rdy;
        pop = (q.size() != 0) && out_ready;
        lg  = m_legal(fmt, Op);
        enc = m_enc(fmt, Op, Rs, Rt, Rd, shamt, funct, imm, addr);
        @(posedge clk);
        #1;
        if (rs_s) begin
            q.delete(); m_cnt = BASE; m_err = 1'b0;
            last_w = 32'h0; last_a = BASE; hold_ok = 1'b1;
        end else if (fl_s) begin
            q.delete(); m_cnt = BASE; m_err = 1'b0; hold_ok = 1'b0;
        end else begin
            if (pop) begin
                e = q.pop_front();
                last_w = e.w; last_a = e.a; hold_ok = 1'b1;
            end
            if (acc) begin
                if (lg) begin
                    q.push_back('{w: enc, a: m_cnt});
                    m_cnt = (m_cnt + 1) % (2**AW);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        bit a;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        cyc(a);
        cyc(a);
        reset = 1'b0;
    endtask

    vec_t tbl[6];

    initial begin
        bit a;
        int k;
        tbl[0] = '{0, 0, 9, 10, 8, 0, 32'h20, 0, 0, 32'h012A4020};
        tbl[1] = '{1, 8, 9, 8, 0, 0, 0, 5, 0, 32'h21280005};
        tbl[2] = '{2, 2, 0, 0, 0, 0, 0, 0, 32'h10, 32'h08000010};
        tbl[3] = '{0, 0, 0, 31, 31, 31, 63, 0, 0, 32'h001FFFFF};
        tbl[4] = '{1, 35, 29, 31, 0, 0, 0, 32'hFFFC, 0, 32'h8FBFFFFC};
        tbl[5] = '{2, 3, 0, 0, 0, 0, 0, 0, 32'h3FFFFFF, 32'h0FFFFFFF};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_waddr", {30'd0, waddr}, 32'(BASE));
        chk("rst_err", {31'd0, err}, 32'd0);
        q.delete(); m_cnt = BASE; m_err = 1'b0; last_w = 32'h0; last_a = BASE; hold_ok = 1'b1;
        reset = 1'b0;

        // Directed table: one word per cycle with out_ready high; waddr wraps after 3.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_fields(tbl[i].f, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd,
                       tbl[i].sh, tbl[i].fn, tbl[i].im, tbl[i].ad);
            in_valid = 1'b1;
            cyc(a);
            chk("tbl_accept", {31'd0, a}, 32'd1);
            chk("tbl_instr", instr, tbl[i].exp);
            chk("tbl_waddr", {30'd0, waddr}, 32'(i % 4));
            chk("tbl_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        cyc(a);

        // Backpressure: three words offered with out_ready low; only two fit.
        do_reset();
        out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            set_fields(2, 2, 0, 0, 0, 0, 0, 0, 100 + k);
            in_valid = (k < 3);
            cyc(a);
            if (a) k++;
        end
        chk("bp_accepted", 32'(k), 32'd2);
        chk("bp_full", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_fields(2, 2, 0, 0, 0, 0, 0, 0, 100 + k);
            in_valid = (k < 3);
            cyc(a);
            if (a) k++;
        end
        chk("bp_all", 32'(k), 32'd3);

        // Flush drops buffered words and restarts addressing.
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_fields(1, 8, 1, 2, 0, 0, 0, 7, 0);
        cyc(a);
        cyc(a);
        flush = 1'b1;
        cyc(a);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_empty", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        set_fields(0, 0, 9, 10, 8, 0, 32'h20, 0, 0);
        cyc(a);
        in_valid = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd1);
        chk("fl_instr", instr, 32'h012A4020);
        chk("fl_waddr", {30'd0, waddr}, 32'(BASE));
        cyc(a);

        // Illegal R-type opcode followed by a legal add.
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_fields(0, 8, 1, 2, 3, 4, 5, 0, 0);
        cyc(a);
        set_fields(0, 0, 9, 10, 8, 0, 32'h20, 0, 0);
        cyc(a);
        in_valid = 1'b0;
        chk("ill_instr", instr, 32'h012A4020);
`ifdef INSTR_ENCODER_CHECK_EN
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_waddr", {30'd0, waddr}, 32'd0);
`else
        chk("ill_err", {31'd0, err}, 32'd0);
        chk("ill_waddr", {30'd0, waddr}, 32'd1);
`endif
        cyc(a);

        // Random traffic with occasional flush and reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            set_fields($urandom_range(0, 3),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 4),
                       $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
                       $urandom_range(0, 32'h3FFFFFF));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            cyc(a);
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        cyc(a);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs MIPS instruction fields into 32-bit instruction words and streams them, with sequential word addresses, toward instruction memory. It is the inverse of the field splitter in the instruction parser: a bench or loader presents Op/Rs/Rt/Rd/shamt/funct/imm/addr plus a format code, and the block emits the encoded word. A 2-entry output FIFO decouples the producer from the memory writer. It sits upstream of instruction-memory initialization and feeds the parser during self-checking tests.

## Interface
- ADDR_W, 10, width of the word write address; the address counter wraps modulo 2^ADDR_W
- BASE_ADDR, 0, address loaded into the counter on reset and on flush
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear: empties the FIFO, reloads the counter, clears err
- in_valid  in  1  field set on inputs is valid
- in_ready  out  1  block can accept a field set this cycle
- fmt  in  2  format: 00 R, 01 I, 10 J, 11 reserved
- Op  in  6  opcode
- Rs, Rt, Rd  in  5 each  register fields
- shamt  in  5  shift amount (R only)
- funct  in  6  function code (R only)
- imm  in  16  immediate (I only)
- addr  in  26  jump target (J only)
- out_valid  out  1  FIFO head holds a word
- out_ready  in  1  consumer takes the head word this cycle
- instr  out  32  encoded word at FIFO head
- waddr  out  ADDR_W  word address paired with instr
- err  out  1  sticky illegal-format flag; constant 0 when checking is compiled out

## Operation
- Encoding: R = {Op, Rs, Rt, Rd, shamt, funct}; I = {Op, Rs, Rt, imm}; J = {Op, addr}. Unused fields are ignored.
- Handshake: a field set is accepted when in_valid & in_ready. A word is popped when out_valid & out_ready.
- in_ready = ~full & ~reset & ~flush. It does not depend on out_ready, so there is no pass-through when the FIFO is full.
- On acceptance of a legal field set:
  - Push {encoded word, current counter} into the FIFO.
  - Increment the counter.
  - When the counter reaches 2^ADDR_W-1, it wraps to 0 on the next push.
- FIFO: 2 entries, in-order, with an occupancy count of 0..2. If a push and a pop happen in the same cycle, occupancy is unchanged.
- out_valid = (occupancy != 0). instr and waddr are the head entry. When occupancy is 0, instr and waddr hold their last values.
- Flush behaviour:
  - Occupancy goes to 0, the counter goes to BASE_ADDR, and err goes to 0.
  - No push occurs, because in_ready is low.
  - Any pop in the same cycle is discarded.
  - flush takes priority over all other activity.
- Reset: same effect as flush.
- Reserved fmt=11: handling depends on configuration (see below).

## Timing
- Reset values: in_ready 0 while reset is high and 1 the cycle after; out_valid 0; instr 0; waddr BASE_ADDR; err 0; counter BASE_ADDR.
- Latency: a field set accepted at edge N appears on instr/waddr with out_valid=1 after edge N, provided the FIFO was empty.
- Throughput: one word per cycle when out_ready is held high.
- Full FIFO: in_ready falls after the 2nd push that is not popped. It rises in the cycle after the first pop.
- Reset or flush mid-stream: all buffered words are lost, and the first word after deassertion carries waddr=BASE_ADDR.
- Counter wrap is silent; no flag is raised.

## Configuration
- Macro: INSTR_ENCODER_CHECK_EN.
- Defined:
  - Legality rules:
    - fmt R requires Op==0.
    - fmt J requires Op in {2,3}.
    - fmt I requires Op not in {0,2,3}.
    - fmt 11 is always illegal.
  - An illegal field set still completes the handshake (in_ready is unchanged), but:
    - nothing is pushed;
    - the counter does not advance;
    - err is set on the following edge and stays set until reset or flush.
- Undefined:
  - No checks are made and err is tied to 0.
  - Every accepted field set is pushed and advances the counter.
  - fmt 11 encodes as 32'h00000000 (nop).

## Test plan
- R-type add: fmt 00, Op 0, Rs 9, Rt 10, Rd 8, shamt 0, funct 0x20 after reset -> next cycle out_valid=1, instr 0x012A4020, waddr 0.
- I-type then J-type back-to-back:
  - Input 1: fmt 01, Op 8, Rs 9, Rt 8, imm 5.
  - Input 2: fmt 10, Op 2, addr 0x10.
  - out_ready=1 throughout.
  - Expected: instr 0x21280005 at waddr 0, then 0x08000010 at waddr 1, on consecutive cycles.
- Backpressure:
  - Hold out_ready=0 and offer 3 words.
  - Expected: in_ready drops after 2 are accepted and the 3rd is held.
  - Then raise out_ready. Expected: words emerge in order at waddr 0, 1, 2.
- Wrap: with ADDR_W=2, push 5 words -> waddr sequence 0, 1, 2, 3, 0.
- Flush: push 2 words with out_ready=0, pulse flush, then push 1 word -> out_valid=0 after the flush, and the new word appears at waddr=BASE_ADDR.
- Illegal format: fmt 00 with Op 8, then a legal R-type word.
  - With INSTR_ENCODER_CHECK_EN: the first word is dropped, err=1, and the legal word lands at waddr 0.
  - Without it: instr 0x2... lands at waddr 0, the legal word at waddr 1, and err stays 0.
